// File: rtl/data_ram_responder_pkg.sv
// Shared types and constants for the data RAM responder slice.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package data_ram_responder_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ramStateT;

  // Byte address of word 0 unless the instance overrides it
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0001_0000;

endpackage

// File: rtl/data_ram_responder_ram.sv
// Word storage built from four byte lanes with per-lane write enables.
// Latency: write commits on the clock edge; read data appears one edge after rdEn.
// Backpressure: none, every enabled access completes on the edge it is presented.
module ram_byte_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic [3:0]       wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [31:0]      wrData,
  input  logic             rdEn,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [31:0]      rdData
);

  for (genvar g = 0; g < 4; g++) begin : gLane
    logic [7:0] laneMem [DEPTH_WORDS];
    logic [7:0] laneQ;

    // One byte lane: independent write strobe, shared read strobe
    always_ff @(posedge clk) begin
      if (wrEn[g]) laneMem[wrIdx] <= wrData[8*g +: 8];
      if (rdEn)    laneQ          <= laneMem[rdIdx];
    end

    assign rdData[8*g +: 8] = laneQ;
  end

endmodule

// File: rtl/data_ram_responder.sv
// Single-port RAM responder: accepts one request, waits, then strobes READY for a cycle.
// Latency: READY arrives WAIT_CYCLES+1 cycles after the cycle the request is accepted in.
// Backpressure: requests are only taken in IDLE; CE is ignored while a request is in flight.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iRAM_CE,
  input  logic        iRAM_WR,
  input  logic [3:0]  iRAM_WSTRB,
  input  logic [31:0] iRAM_ADDR,
  input  logic [31:0] iRAM_DATA,
  output logic [31:0] oRAM_RDATA,
  output logic        oRAM_READY,
  output logic        oRAM_ERR
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  ramStateT    state, stateNxt;
  logic [3:0]  waitCnt, waitCntNxt;

  logic        reqWr;
  logic [3:0]  reqStrb;
  logic [31:0] reqAddr;
  logic [31:0] reqData;

  // With zero wait states the RESP-entry edge is the acceptance edge, so the
  // live inputs must be used in IDLE; otherwise the latched copy is used.
  logic        curWr;
  logic [3:0]  curStrb;
  logic [31:0] curAddr;
  logic [31:0] curData;
  assign curWr   = (state == IDLE) ? iRAM_WR    : reqWr;
  assign curStrb = (state == IDLE) ? iRAM_WSTRB : reqStrb;
  assign curAddr = (state == IDLE) ? iRAM_ADDR  : reqAddr;
  assign curData = (state == IDLE) ? iRAM_DATA  : reqData;

  logic [31:0] wordOfs;
  logic [31:0] wordIdx;
  logic        inRange;
  logic        reqErr;
  logic        enterResp;
  assign wordOfs   = curAddr - BASE_ADDR;
  assign wordIdx   = wordOfs >> 2;
  assign inRange   = (curAddr >= BASE_ADDR) && (wordIdx < 32'(DEPTH_WORDS));
  assign reqErr    = !inRange || (curWr && (curStrb == 4'b0000));
  assign enterResp = (stateNxt == RESP);

  logic [3:0]  ramWrEn;
  logic        ramRdEn;
  logic [31:0] ramRdData;
  // Reset gating keeps an aborted request from touching the unreset array
  assign ramWrEn = {4{enterResp && curWr && inRange && iRST_N}} & curStrb;
  assign ramRdEn = enterResp && !curWr && inRange;

  ram_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) uArray (
    .clk   (iCLK),
    .wrEn  (ramWrEn),
    .wrIdx (wordIdx[IDX_W-1:0]),
    .wrData(curData),
    .rdEn  (ramRdEn),
    .rdIdx (wordIdx[IDX_W-1:0]),
    .rdData(ramRdData)
  );

  // Next-state and wait counter
  always_comb begin
    stateNxt   = state;
    waitCntNxt = waitCnt;
    case (state)
      IDLE: begin
        if (iRAM_CE) begin
          if (WAIT_CYCLES > 0) begin
            stateNxt   = WAIT;
            waitCntNxt = WAIT_LOAD;
          end else begin
            stateNxt = RESP;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) stateNxt = RESP;
        else                 waitCntNxt = waitCnt - 4'd1;
      end
      RESP:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitCntNxt;
    end
  end

  // Capture the request on acceptance so inputs may change afterwards
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      reqWr   <= 1'b0;
      reqStrb <= 4'b0000;
      reqAddr <= 32'h0;
      reqData <= 32'h0;
    end else if ((state == IDLE) && iRAM_CE) begin
      reqWr   <= iRAM_WR;
      reqStrb <= iRAM_WSTRB;
      reqAddr <= iRAM_ADDR;
      reqData <= iRAM_DATA;
    end
  end

  // Response registers: error flag lives only in RESP, rdZero masks read data
  // after reset and after an out-of-range read
  logic errQ;
  logic rdZero;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      errQ   <= 1'b0;
      rdZero <= 1'b1;
    end else begin
      errQ <= enterResp && reqErr;
      if (enterResp && !curWr) rdZero <= !inRange;
    end
  end

  assign oRAM_READY = (state == RESP);
  assign oRAM_ERR   = errQ;
  assign oRAM_RDATA = rdZero ? 32'h0 : ramRdData;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: two instances (one and zero wait states) against a word-array model.
// Latency: checks READY arrives WAIT_CYCLES+1 cycles after the accepting cycle.
// Backpressure: drives one request at a time per instance, plus a held-CE back-to-back case.
module tb_data_ram_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rstN;
  logic        ce   [2];
  logic        wr   [2];
  logic [3:0]  strb [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        err  [2];

  // Reference model: plain word array per instance plus last read value
  logic [31:0] mem    [2][DEPTH];
  logic [31:0] lastRd [2];

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) uW1 (
    .iCLK(clk), .iRST_N(rstN), .iRAM_CE(ce[0]), .iRAM_WR(wr[0]), .iRAM_WSTRB(strb[0]),
    .iRAM_ADDR(addr[0]), .iRAM_DATA(wdat[0]), .oRAM_RDATA(rdat[0]), .oRAM_READY(rdy[0]),
    .oRAM_ERR(err[0]));

  data_ram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) uW0 (
    .iCLK(clk), .iRST_N(rstN), .iRAM_CE(ce[1]), .iRAM_WR(wr[1]), .iRAM_WSTRB(strb[1]),
    .iRAM_ADDR(addr[1]), .iRAM_DATA(wdat[1]), .oRAM_RDATA(rdat[1]), .oRAM_READY(rdy[1]),
    .oRAM_ERR(err[1]));

  function automatic int waitOf(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit outOfRange(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
  endfunction

  // One complete transaction; expectations come from the model, which is then updated
  task automatic doReq(input int d, input bit w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] dat, input string tag);
    bit          oor;
    bit          expErr;
    int          idx;
    int          cycles;
    logic [31:0] expRd;
    oor    = outOfRange(a);
    expErr = oor || (w && (s == 4'b0000));
    idx    = oor ? 0 : int'((a - BASE) >> 2);
    if (w)        expRd = lastRd[d];
    else if (oor) expRd = 32'h0;
    else          expRd = mem[d][idx];

    ce[d] = 1'b1; wr[d] = w; strb[d] = s; addr[d] = a; wdat[d] = dat;
    @(posedge clk); #1;
    // Inputs are don't-care once accepted: scramble them
    ce[d] = 1'b0; wr[d] = 1'($urandom); strb[d] = 4'($urandom);
    addr[d] = $urandom; wdat[d] = $urandom;
    cycles = 1;
    while (!rdy[d] && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, " latency"}, cycles, waitOf(d) + 1);
    check({tag, " err"},     err[d], expErr);
    check({tag, " rdata"},   rdat[d], expRd);
    @(posedge clk); #1;
    check({tag, " ready drop"}, rdy[d], 1'b0);
    check({tag, " err idle"},   err[d], 1'b0);

    if (w && !expErr)
      for (int l = 0; l < 4; l++)
        if (s[l]) mem[d][idx][8*l +: 8] = dat[8*l +: 8];
    if (!w) lastRd[d] = expRd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < 2; d++) begin
      ce[d] = 1'b0; wr[d] = 1'b0; strb[d] = 4'b0; addr[d] = 32'h0; wdat[d] = 32'h0;
      lastRd[d] = 32'h0;
    end
    rstN = 1'b0;
    #23;
    for (int d = 0; d < 2; d++) begin
      check("reset ready", rdy[d], 1'b0);
      check("reset err",   err[d], 1'b0);
      check("reset rdata", rdat[d], 32'h0);
    end

    // First request right after reset release, away from the clock edge
    @(negedge clk);
    rstN = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        doReq(d, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom, "preload");

    // Full write and readback with one wait state
    doReq(0, 1'b1, 4'hF, 32'h0001_0010, 32'hDEADBEEF, "wr deadbeef");
    doReq(0, 1'b0, 4'h0, 32'h0001_0010, 32'h0, "rd deadbeef");
    check("deadbeef const", rdat[0], 32'hDEADBEEF);

    // Single-lane merge
    doReq(0, 1'b1, 4'hF, 32'h0001_0004, 32'h11223344, "preload merge");
    doReq(0, 1'b1, 4'b0010, 32'h0001_0004, 32'h0000AA00, "wr lane1");
    doReq(0, 1'b0, 4'h0, 32'h0001_0007, 32'h0, "rd merged");
    check("merged const", rdat[0], 32'h1122AA44);

    // Out-of-range writes and reads on both sides of the window
    doReq(0, 1'b1, 4'hF, 32'h0000_FFFC, 32'h55555555, "wr below");
    doReq(0, 1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'h66666666, "wr above");
    doReq(0, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0, "rd below");
    doReq(0, 1'b0, 4'h0, BASE + 32'(4 * DEPTH), 32'h0, "rd above");
    doReq(0, 1'b0, 4'h0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, "rd last word");
    doReq(0, 1'b0, 4'h0, BASE, 32'h0, "rd first word");

    // Empty strobe is an error and leaves the word untouched
    doReq(1, 1'b1, 4'b0000, 32'h0001_0020, 32'h77777777, "wr nostrb");
    doReq(1, 1'b0, 4'h0, 32'h0001_0020, 32'h0, "rd nostrb");

    // Zero wait states, CE held through two writes
    ce[1] = 1'b1; wr[1] = 1'b1; strb[1] = 4'hF; addr[1] = 32'h0001_0030; wdat[1] = 32'hA5A5_0001;
    @(posedge clk); #1;
    check("b2b first ready", rdy[1], 1'b1);
    check("b2b first err",   err[1], 1'b0);
    addr[1] = 32'h0001_0034; wdat[1] = 32'hA5A5_0002;
    @(posedge clk); #1;
    check("b2b gap ready", rdy[1], 1'b0);
    @(posedge clk); #1;
    check("b2b second ready", rdy[1], 1'b1);
    check("b2b second err",   err[1], 1'b0);
    ce[1] = 1'b0;
    @(posedge clk); #1;
    mem[1][12] = 32'hA5A5_0001;
    mem[1][13] = 32'hA5A5_0002;
    doReq(1, 1'b0, 4'h0, 32'h0001_0030, 32'h0, "rd b2b first");
    doReq(1, 1'b0, 4'h0, 32'h0001_0034, 32'h0, "rd b2b second");

    // Randomized mix on both instances
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 100)) + 32'($urandom_range(0, 3));
      else             a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100)) + 32'($urandom_range(0, 3));
      doReq($urandom_range(0, 1), 1'($urandom), 4'($urandom), a, $urandom, "random");
    end

    // Reset during the wait state of a write aborts it
    doReq(0, 1'b1, 4'hF, 32'h0001_0040, 32'h12345678, "wr before abort");
    doReq(0, 1'b0, 4'h0, 32'h0001_0040, 32'h0, "rd before abort");
    @(negedge clk);
    ce[0] = 1'b1; wr[0] = 1'b1; strb[0] = 4'hF; addr[0] = 32'h0001_0040; wdat[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    ce[0] = 1'b0;
    check("abort in wait", rdy[0], 1'b0);
    rstN = 1'b0;
    #1;
    check("abort ready", rdy[0], 1'b0);
    check("abort err",   err[0], 1'b0);
    check("abort rdata", rdat[0], 32'h0);
    check("abort other rdata", rdat[1], 32'h0);
    lastRd[0] = 32'h0;
    lastRd[1] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    doReq(0, 1'b0, 4'h0, 32'h0001_0040, 32'h0, "rd after abort");
    check("abort kept const", rdat[0], 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
